// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and default operand width for serial_subtractor.
//   DEFAULT_WIDTH : default WIDTH parameter of serial_subtractor
//   state_t       : ST_IDLE / ST_SHIFT / ST_DONE
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// fullsubtractor: single-bit combinational subtract cell, d = a - b - b_in.
//   a, b  : operand bits
//   b_in  : incoming borrow
//   d     : difference bit
//   b_out : outgoing borrow
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock behind a start/busy/done handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request; a and b are sampled when it is accepted (IDLE or DONE)
//   a, b       : minuend, subtrahend
//   busy       : high while bits are being shifted
//   done       : one-cycle pulse when diff/borrow_out become valid
//   diff       : a - b modulo 2^WIDTH, held until the next result
//   borrow_out : final borrow (a < b unsigned)
//   ovf        : signed overflow, only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, res_nx;
    logic [WIDTH-2:0] r_sr;
    logic [CW-1:0]    cnt;
    logic             borrow, d, bo, last, accept;

    fullsubtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .b_in (borrow),
        .d    (d),
        .b_out(bo)
    );

    // Partial result with the current bit entered at the MSB; after the
    // final bit this is the complete difference.
    assign res_nx = {d, r_sr};
    assign last   = cnt == CW'(WIDTH - 1);

    always_comb begin
        accept   = start && (state != ST_SHIFT);
        busy     = state == ST_SHIFT;
        done     = state == ST_DONE;
        state_nx = accept ? ST_SHIFT : (state == ST_SHIFT) ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == ST_SHIFT && last) begin
            // d is the result MSB on the final shift
            ovf <= (a_msb ^ b_msb) & (a_msb ^ d);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            r_sr       <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            r_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == ST_SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            r_sr   <= res_nx[WIDTH-1:1];
            borrow <= bo;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff       <= res_nx;
                borrow_out <= bo;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit armed = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: cycles remaining until the result, and the arithmetic result
    // of the accepted operands published when that count runs out.
    int           m_left = 0;
    bit           m_done = 0, m_bo = 0, m_ovf = 0;
    logic [W-1:0] m_diff = '0, pa = '0, pb = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_diff = '0; m_bo = 0; m_ovf = 0;
        end else if (m_left == 0 && start) begin
            m_left = W; m_done = 0; pa = a; pb = b;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                int s;
                s = int'($signed(pa)) - int'($signed(pb));
                m_done = 1;
                m_diff = pa - pb;
                m_bo   = pa < pb;
                m_ovf  = (s > 127) || (s < -128);
            end
        end else begin
            m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("diff", diff, m_diff);
            chk("borrow_out", borrow_out, m_bo);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", ovf, m_ovf);
`endif
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL done_timeout actual=0 expected=1 at %0t", $time);
        end
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] ed, input bit eb);
        start = 1'b1; a = x; b = y;
        tick();
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        wait_done();
        chk("lit_diff", diff, ed);
        chk("lit_borrow", borrow_out, eb);
        chk("model_diff", m_diff, ed);
        #1;
    endtask

    initial begin
        int dc0;
        repeat (3) tick();
        rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_diff", diff, 0);
        #1;

        // basic: busy for W cycles, then done
        dc0 = done_cnt;
        op(8'd100, 8'd37, 8'd63, 1'b0);
        op(8'd5, 8'd10, 8'd251, 1'b1);
`ifdef SERIAL_SUB_OVF_EN
        chk("lit_ovf_5_10", ovf, 0);
`endif
        op(8'd77, 8'd77, 8'd0, 1'b0);
        op(8'd0, 8'd255, 8'd1, 1'b1);
        chk("done_count_basic", done_cnt - dc0, 4);

        // start while busy is ignored
        dc0 = done_cnt;
        start = 1'b1; a = 8'd20; b = 8'd3;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'd0; b = 8'd1;
        tick();
        start = 1'b0;
        wait_done();
        chk("ignore_diff", diff, 8'd17);
        #1;
        tick(); tick();
        chk("ignore_done_count", done_cnt - dc0, 1);

        // back-to-back with start held high
        dc0 = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a = W'($urandom); b = W'($urandom);
            tick();
        end
        start = 1'b0;
        tick(); tick();
        chk("b2b_done_count", done_cnt - dc0, 5);

        // reset mid-operation
        dc0 = done_cnt;
        start = 1'b1; a = 8'd90; b = 8'd12;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_diff", diff, 0);
        chk("abort_done", done, 0);
        #1;
        repeat (12) tick();
        chk("abort_done_count", done_cnt - dc0, 0);
        op(8'd200, 8'd55, 8'd145, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        op(8'h80, 8'h01, 8'h7F, 1'b0);
        chk("lit_ovf_80_01", ovf, 1);
        op(8'h7F, 8'hFF, 8'h80, 1'b1);
        chk("lit_ovf_7f_ff", ovf, 1);
`endif

        // random traffic with occasional resets and starts during busy
        for (int i = 0; i < 1500; i++) begin
            start = $urandom_range(0, 3) == 0;
            a = W'($urandom); b = W'($urandom);
            rst = $urandom_range(0, 199) == 0;
            tick();
        end
        rst = 1'b0; start = 1'b0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor: computes diff = a - b, LSB first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- Inverse-direction companion to the team's full-adder arithmetic cell.
- Sits behind a start/busy/done handshake, so a small ALU/datapath controller can issue subtractions without a WIDTH-bit parallel subtractor.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; operands sampled on the cycle it is accepted.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accept.
- borrow_out  output  1  final borrow: 1 when a < b unsigned.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, ovf=0, internal shift registers, bit counter and borrow cleared.
- Reset mid-operation: abort immediately; no done pulse; prior result discarded (outputs zero).
- FSM states:
  - IDLE: busy=0. start=1 -> load a_sr=a, b_sr=b, borrow=0, cnt=0; go to SHIFT.
  - SHIFT: busy=1. Each cycle computes:
    - d = a_sr[0]^b_sr[0]^borrow
    - bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow)
    - Shift a_sr and b_sr right by one; shift d into the result-register MSB; borrow<=bo; cnt<=cnt+1.
    - After the WIDTH-th bit (cnt==WIDTH-1): go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0; diff and borrow_out are valid from this cycle and held.
    - start=1 here -> accept as in IDLE, go to SHIFT (back-to-back).
    - Otherwise -> IDLE.
- Latency: start accepted at cycle 0 -> done high at cycle WIDTH+1. Throughput one result per WIDTH+1 cycles.
- start while busy=1: ignored; a and b are not resampled; no queueing.
- a and b may change freely after the accept cycle.
- diff and borrow_out update only at the transition into DONE (taken from the shift register), never mid-operation.
- Counter width: $clog2(WIDTH). No wrap is reachable past WIDTH-1.
- Boundaries: a==b -> diff=0, borrow_out=0; a=0, b=2^WIDTH-1 -> diff=1, borrow_out=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined: port ovf exists. It is registered at DONE as (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the MSBs captured at accept; it is held with diff and reset to 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg: FSM state encoding localparams (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2); default WIDTH constant.
- Sub-module fullsubtractor: combinational, inputs a, b, b_in; outputs d, b_out. It is the only arithmetic in the block, instantiated once.
- The FSM, shift registers and counter stay in serial_subtractor.

Test Plan:
- Reset, then a=8'd100, b=8'd37, start pulse -> busy=1 for 8 cycles; done at cycle 9; diff=8'd63, borrow_out=0.
- a=8'd5, b=8'd10 -> diff=8'd251, borrow_out=1; with SERIAL_SUB_OVF_EN, ovf=0.
- Start accepted with a=8'd20, b=8'd3; start re-asserted at cycle 3 with a=8'd0, b=8'd1 -> ignored; done once at cycle 9 with diff=8'd17.
- start held high continuously with new operands each DONE cycle -> results every 9 cycles, no idle gap; each diff correct.
- rst asserted at cycle 4 of an operation -> next cycle busy=0, diff=0, no done pulse; a new start afterwards completes normally.
- SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, borrow_out=0; a=8'h7F, b=8'hFF -> diff=8'h80, ovf=1, borrow_out=1.
